dm_bytelane: RTL and testbench



---
 rtl/dm_pkg.sv | 35 +++
 rtl/dm_rd_pipe.sv | 33 +++
 rtl/dm_bytelane.sv | 128 ++++++++++++
 tb/tb_dm_bytelane.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared constants, types and load extraction for dm_bytelane
package dm_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } rd_beat_t;

  // Picks the addressed byte/half out of a little-endian word and extends it.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [1:0]  size,
                                               input logic        sext);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_BYTE: r = {{24{sext & b[7]}}, b};
      SIZE_HALF: r = {{16{sext & h[15]}}, h};
      default:   r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dm_rd_pipe.sv
// rtl/dm_rd_pipe.sv - RD_LAT-deep response pipeline carrying valid, err and data
module dm_rd_pipe
  import dm_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        flush_n_i,
  input  logic        valid_i,
  input  logic        err_i,
  input  logic [31:0] data_i,
  output logic        valid_o,
  output logic        err_o,
  output logic [31:0] data_o
);

  rd_beat_t st_q [RD_LAT];

  // Shift one beat per cycle; a flush drops everything in flight.
  always_ff @(posedge clk) begin
    if (!flush_n_i) begin
      for (int i = 0; i < RD_LAT; i++) st_q[i] <= '0;
    end else begin
      st_q[0] <= '{valid: valid_i, err: err_i, data: data_i};
      for (int i = 1; i < RD_LAT; i++) st_q[i] <= st_q[i-1];
    end
  end

  assign valid_o = st_q[RD_LAT-1].valid;
  assign err_o   = st_q[RD_LAT-1].err;
  assign data_o  = st_q[RD_LAT-1].data;

endmodule

// File: rtl/dm_bytelane.sv
// rtl/dm_bytelane.sv - byte-lane data memory with hardware clear and pipelined reads
module dm_bytelane
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int RD_LAT      = 1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        sext_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] din_i,
  output logic        ready_o,
  output logic        rvalid_o,
  output logic [31:0] dout_o,
  output logic        err_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [31:0]      mem_q [DEPTH_WORDS];

  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             accept;
  logic             req_err;
  logic             do_store;
  logic             ld_ok;
  logic [3:0]       st_be;
  logic [31:0]      st_data;
  logic [31:0]      ld_data;

  assign idx     = addr_i[IDX_W+1:2];
  assign lane    = addr_i[1:0];
  // Gated by rstn so nothing is accepted in a reset cycle even from RUN.
  assign ready_o = rstn && (state_q == ST_RUN);
  assign accept  = req_i && ready_o;

  // Alignment, size and range faults.
  always_comb begin
    req_err = 1'b0;
    if (size_i == 2'b11) req_err = 1'b1;
    if (size_i == SIZE_HALF && addr_i[0]) req_err = 1'b1;
    if (size_i == SIZE_WORD && addr_i[1:0] != 2'b00) req_err = 1'b1;
    if (|addr_i[31:IDX_W+2]) req_err = 1'b1;
  end

  assign do_store = accept && we_i && !req_err;
  assign ld_ok    = accept && !we_i && !req_err;

  // Lane enables and lane-replicated store data.
  always_comb begin
    st_be   = 4'b0000;
    st_data = din_i;
    case (size_i)
      SIZE_BYTE: begin
        st_be   = 4'b0001 << lane;
        st_data = {4{din_i[7:0]}};
      end
      SIZE_HALF: begin
        st_be   = lane[1] ? 4'b1100 : 4'b0011;
        st_data = {2{din_i[15:0]}};
      end
      SIZE_WORD: begin
        st_be   = 4'b1111;
        st_data = din_i;
      end
      default: begin
        st_be   = 4'b0000;
        st_data = din_i;
      end
    endcase
  end

  // Clear walks every word once, then hands over to RUN.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (state_q == ST_CLEAR) begin
      clr_ptr_d = clr_ptr_q + 1'b1;
      if (clr_ptr_q == IDX_W'(DEPTH_WORDS - 1)) state_d = ST_RUN;
    end
  end

  // FSM and clear pointer registers.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= ST_CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // Array write port: clear first, otherwise lane-masked store.
  always_ff @(posedge clk) begin
    if (rstn && state_q == ST_CLEAR) begin
      mem_q[clr_ptr_q] <= '0;
    end else if (do_store) begin
      for (int i = 0; i < 4; i++) begin
        if (st_be[i]) mem_q[idx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

  // Read is combinational from the array so the accept edge captures the current word.
  assign ld_data = ld_ok ? load_extract(mem_q[idx], lane, size_i, sext_i) : 32'h0;

  dm_rd_pipe #(
    .RD_LAT(RD_LAT)
  ) u_rd_pipe (
    .clk      (clk),
    .flush_n_i(rstn),
    .valid_i  (ld_ok),
    .err_i    (accept && req_err),
    .data_i   (ld_data),
    .valid_o  (rvalid_o),
    .err_o    (err_o),
    .data_o   (dout_o)
  );

endmodule

// File: tb/tb_dm_bytelane.sv
// tb/tb_dm_bytelane.sv - directed self-checking bench for dm_bytelane at RD_LAT 1 and 2
module tb_dm_bytelane;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_i = 1'b0;
  logic        we_i = 1'b0;
  logic [1:0]  size_i = 2'b00;
  logic        sext_i = 1'b0;
  logic [31:0] addr_i = '0;
  logic [31:0] din_i = '0;

  logic        rdy1, rv1, er1;
  logic [31:0] do1;
  logic        rdy2, rv2, er2;
  logic [31:0] do2;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int          acc;
    bit          is_err;
    logic [31:0] data;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dm_bytelane #(.DEPTH_WORDS(16), .RD_LAT(1)) u_lat1 (
    .clk(clk), .rstn(rstn), .req_i(req_i), .we_i(we_i), .size_i(size_i),
    .sext_i(sext_i), .addr_i(addr_i), .din_i(din_i), .ready_o(rdy1),
    .rvalid_o(rv1), .dout_o(do1), .err_o(er1)
  );

  dm_bytelane #(.DEPTH_WORDS(16), .RD_LAT(2)) u_lat2 (
    .clk(clk), .rstn(rstn), .req_i(req_i), .we_i(we_i), .size_i(size_i),
    .sext_i(sext_i), .addr_i(addr_i), .din_i(din_i), .ready_o(rdy2),
    .rvalid_o(rv2), .dout_o(do2), .err_o(er2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Response monitor for the RD_LAT=1 instance.
  always @(negedge clk) begin : mon1
    exp_t e;
    if (mon_en) begin
      if (rv1 || er1) begin
        chk("l1_both", 32'(rv1 && er1), 32'd0);
        if (q1.size() == 0) chk("l1_spurious", 32'd1, 32'd0);
        else begin
          e = q1.pop_front();
          chk("l1_lat", 32'(cyc), 32'(e.acc));
          chk("l1_err", 32'(er1), 32'(e.is_err));
          chk("l1_data", do1, e.is_err ? 32'h0 : e.data);
        end
      end else chk("l1_idle_dout", do1, 32'h0);
    end
  end

  // Response monitor for the RD_LAT=2 instance.
  always @(negedge clk) begin : mon2
    exp_t e;
    if (mon_en) begin
      if (rv2 || er2) begin
        chk("l2_both", 32'(rv2 && er2), 32'd0);
        if (q2.size() == 0) chk("l2_spurious", 32'd1, 32'd0);
        else begin
          e = q2.pop_front();
          chk("l2_lat", 32'(cyc), 32'(e.acc + 1));
          chk("l2_err", 32'(er2), 32'(e.is_err));
          chk("l2_data", do2, e.is_err ? 32'h0 : e.data);
        end
      end else chk("l2_idle_dout", do2, 32'h0);
    end
  end

  task automatic send(input logic we, input logic [1:0] sz, input logic sx,
                      input logic [31:0] a, input logic [31:0] d,
                      input bit resp, input bit e, input logic [31:0] ed);
    exp_t x;
    @(negedge clk);
    req_i = 1'b1; we_i = we; size_i = sz; sext_i = sx; addr_i = a; din_i = d;
    if (resp) begin
      x.acc = cyc + 1; x.is_err = e; x.data = ed;
      q1.push_back(x);
      q2.push_back(x);
    end
  endtask

  task automatic lw(input logic [31:0] a, input logic [31:0] ed);
    send(1'b0, SZ_W, 1'b0, a, 32'h0, 1'b1, 1'b0, ed);
  endtask

  task automatic ld(input logic [1:0] sz, input logic sx, input logic [31:0] a, input logic [31:0] ed);
    send(1'b0, sz, sx, a, 32'h0, 1'b1, 1'b0, ed);
  endtask

  task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    send(1'b1, sz, 1'b0, a, d, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic bad(input logic we, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    send(we, sz, 1'b0, a, d, 1'b1, 1'b1, 32'h0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      req_i = 1'b0;
    end
  endtask

  // Asserts rstn at the current negedge, holds two edges, releases and times ready.
  task automatic reset_cycle(input string tag);
    int n;
    rstn = 1'b0;
    req_i = 1'b0;
    repeat (2) @(negedge clk);
    chk({tag, "_rst_rdy"}, 32'({rdy1, rdy2}), 32'd0);
    chk({tag, "_rst_resp"}, 32'({rv1, er1, rv2, er2}), 32'd0);
    chk({tag, "_rst_dout"}, do1 | do2, 32'h0);
    rstn = 1'b1;
    n = 0;
    while (!rdy1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_clr_cycles"}, 32'(n), 32'd16);
    chk({tag, "_rdy2"}, 32'(rdy2), 32'd1);
  endtask

  initial begin
    @(negedge clk);
    reset_cycle("init");
    mon_en = 1'b1;

    for (int i = 0; i < 16; i++) lw(32'(i * 4), 32'h0);

    st(SZ_W, 32'h10, 32'h8899AABB);
    ld(SZ_B, 1'b1, 32'h11, 32'hFFFFFFAA);
    ld(SZ_B, 1'b0, 32'h11, 32'h000000AA);
    ld(SZ_H, 1'b1, 32'h12, 32'hFFFF8899);
    ld(SZ_H, 1'b0, 32'h12, 32'h00008899);

    st(SZ_W, 32'h20, 32'h11223344);
    st(SZ_B, 32'h22, 32'h000000EE);
    st(SZ_H, 32'h20, 32'h00005566);
    lw(32'h20, 32'h11EE5566);
    ld(SZ_B, 1'b1, 32'h23, 32'h00000011);
    idle(3);

    bad(1'b0, SZ_H, 32'h01, 32'h0);
    bad(1'b1, SZ_W, 32'h02, 32'hDEADBEEF);
    bad(1'b0, 2'b11, 32'h00, 32'h0);
    bad(1'b0, SZ_W, 32'h40, 32'h0);
    bad(1'b1, SZ_B, 32'h44, 32'h00000077);
    lw(32'h00, 32'h0);
    lw(32'h04, 32'h0);
    idle(3);
    chk("pre_rst_q1", 32'(q1.size()), 32'd0);
    chk("pre_rst_q2", 32'(q2.size()), 32'd0);

    lw(32'h10, 32'h8899AABB);
    @(negedge clk);
    reset_cycle("mid");
    chk("mid_q1_done", 32'(q1.size()), 32'd0);
    chk("mid_q2_dropped", 32'(q2.size()), 32'd1);
    q2.delete();

    lw(32'h10, 32'h0);
    lw(32'h20, 32'h0);
    idle(4);
    chk("end_q1", 32'(q1.size()), 32'd0);
    chk("end_q2", 32'(q2.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
